dirty_recompute: RTL
====================

Name: dirty_recompute

Overview:
- Multi-channel evaluator that recomputes a costly per-channel function only for channels whose input changed.
- Uses one shared, pipelined function unit and a round-robin scheduler instead of N parallel copies.
- Tracks staleness per channel so downstream logic knows which outputs are current.
- Sits between a vector of slowly-changing status inputs and consumers of derived per-channel values.

Parameters:
- N_CHAN, 5, number of channels; must be ≥ 2.
- W_IN, 8, bit width of each channel input.
- W_OUT, 8, bit width of each channel result.
- PIPE_STAGES, 2, register stages inside the function unit; must be ≥ 1.

Ports:
- i_clk  input  1  clock.
- i_arst_n  input  1  asynchronous active-low reset.
- i_x  input  N_CHAN*W_IN  channel inputs, flattened; channel c is at [c*W_IN +: W_IN].
- o_y  output  N_CHAN*W_OUT  channel results, same flattening.
- o_valid  output  N_CHAN  o_y channel is current with respect to i_x.
- o_busy  output  1  any channel is dirty or in flight.

Behaviour:
- Clock and reset: one clock, i_clk; reset i_arst_n is asynchronous, active-low.
- Function: f(x) = (x*x) truncated to its low W_OUT bits. The square is 2*W_IN bits wide; zero-extend if W_OUT is wider.
- Reset values: xPrev=0, dirty=0, inflight=0, o_y=0, pipeline valid bits=0, rrPtr=N_CHAN-1.
  - Therefore o_valid=all ones and o_busy=0 out of reset, which is consistent because f(0)=0.
- Change detect: changed[c] = (i_x[c] != xPrev[c]). xPrev <= i_x every cycle.
- Dirty update: dirty[c] <= changed[c] | (dirty[c] & ~issue[c]). Set wins over clear when both happen in one cycle.
- Scheduler:
  - Each cycle, grant at most one dirty channel.
  - Search starts at rrPtr+1 modulo N_CHAN; take the first dirty channel found.
  - On a grant, rrPtr <= granted channel.
  - No dirty channel means no issue, and rrPtr holds.
- Issue:
  - Operand is xPrev[granted], the registered copy.
  - Channel index travels with the operand through the pipeline.
  - inflight[c] is set on issue and cleared on writeback.
  - The same channel may be reissued while already in flight.
  - inflight is a per-channel counter, width clog2(PIPE_STAGES+1); a 1-bit flag is only sufficient when PIPE_STAGES=1.
- Writeback: the final pipe stage writes o_y[ch] on the next edge. An older result for a reissued channel is overwritten later by the newer one.
- Latency: for an isolated change sampled at edge E0 with the scheduler idle, o_y updates and o_valid rises at edge E0+PIPE_STAGES+1.
- o_valid[c] = ~dirty[c] & (inflight[c]==0), from registers only.
- o_busy = |dirty | (any inflight nonzero).
- Worst case: all channels change together. Channel k in grant order updates at E0+PIPE_STAGES+1+k. Throughput is one issue per cycle.
- Change while in flight: dirty is set again and o_valid stays low. The stale result still writes o_y, then the channel is reissued.
- i_x changing every cycle on one channel: that channel stays dirty and o_valid stays 0. Other channels are not starved.
- Reset mid-operation: all state returns to reset values immediately. Pending work is discarded.

Optional Feature:
- Macro: DIRTY_RECOMPUTE_ISSUECOUNT_EN.
- Defined: adds output o_nIssued, 16 bits, wide enough to count issues from reset.
  - Increments once per issue and saturates at 0xFFFF.
  - Resets to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package dirty_recompute_pkg holds:
  - function f;
  - localparam helper for the channel-index width, clog2(N_CHAN);
  - typedef for the pipeline payload struct {valid, chan, data}.
- One sub-module, dirty_recompute_func: pipelined f with PIPE_STAGES stages, carrying the payload sideband.
- The round-robin arbiter stays inline in dirty_recompute.

Test Plan (all with N_CHAN=5, W_IN=8, W_OUT=8, PIPE_STAGES=2):
- Reset then idle 10 cycles -> o_y=0, o_valid=5'b11111, o_busy=0 throughout.
- Channel 2 set 0->7 sampled at E0 -> o_valid[2]=0 from E0; o_y[2]=49 (0x31) and o_valid[2]=1 at E0+3; other channels undisturbed.
- All channels set to 16 at once -> issue order 0,1,2,3,4; each o_y=0x00 (256 truncated); channel k valid at E0+3+k; o_busy falls at E0+7.
- Channel 1 set 3->5 at E0, then 5->9 at E0+1 (in flight) -> o_y[1] passes through 25, final value 81; o_valid[1] stays 0 until the final write.
- Channel 0 toggled every cycle while channel 3 changes once -> channel 3 still updates within N_CHAN+PIPE_STAGES+1 cycles; o_valid[0] stays 0.
- i_arst_n asserted mid-burst, then released -> o_y=0, o_valid all ones, o_busy=0. With ISSUECOUNT_EN defined, o_nIssued=0, then counts issues exactly.

Source files
------------

// File: rtl/dirty_recompute_pkg.sv
// Shared configuration, the per-channel square function and the pipeline payload type.
// The payload field widths follow the DEF_* values below, so re-size here rather than per instance.
package dirty_recompute_pkg;

    localparam int DEF_N_CHAN      = 5;
    localparam int DEF_W_IN        = 8;
    localparam int DEF_W_OUT       = 8;
    localparam int DEF_PIPE_STAGES = 2;

    localparam int CHAN_W = (DEF_N_CHAN > 1) ? $clog2(DEF_N_CHAN) : 1;

    // Wide enough for the full square plus zero-extension when W_OUT exceeds 2*W_IN.
    localparam int SQ_W = 2 * DEF_W_IN + DEF_W_OUT;

    typedef struct packed {
        logic                 valid;
        logic [CHAN_W-1:0]    chan;
        logic [DEF_W_OUT-1:0] data;
    } payload_t;

    function automatic logic [DEF_W_OUT-1:0] f(input logic [DEF_W_IN-1:0] x);
        logic [SQ_W-1:0] x_ext;
        x_ext = SQ_W'(x);
        return DEF_W_OUT'(x_ext * x_ext);
    endfunction

endpackage

// File: rtl/dirty_recompute_func.sv
// Pipelined square unit: f is evaluated on entry, then the result and its channel tag
// travel through PIPE_STAGES registers.
module dirty_recompute_func
    import dirty_recompute_pkg::*;
#(
    parameter int W_IN        = DEF_W_IN,
    parameter int PIPE_STAGES = DEF_PIPE_STAGES
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              i_valid,
    input  logic [CHAN_W-1:0] i_chan,
    input  logic [W_IN-1:0]   i_x,
    output payload_t          o_res
);

    payload_t stage_q [PIPE_STAGES];
    payload_t stage_d [PIPE_STAGES];

    always_comb begin
        stage_d[0].valid = i_valid;
        stage_d[0].chan  = i_chan;
        stage_d[0].data  = f(i_x);
        for (int s = 1; s < PIPE_STAGES; s++) begin
            stage_d[s] = stage_q[s-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                stage_q[s] <= stage_d[s];
            end
        end
    end

    assign o_res = stage_q[PIPE_STAGES-1];

endmodule

// File: rtl/dirty_recompute.sv
// Recomputes f only for channels whose input changed, sharing one pipelined unit via round-robin.
// Define DIRTY_RECOMPUTE_ISSUECOUNT_EN to add the saturating o_nIssued issue counter.
module dirty_recompute
    import dirty_recompute_pkg::*;
#(
    parameter int N_CHAN      = DEF_N_CHAN,
    parameter int W_IN        = DEF_W_IN,
    parameter int W_OUT       = DEF_W_OUT,
    parameter int PIPE_STAGES = DEF_PIPE_STAGES
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic [N_CHAN*W_IN-1:0]   i_x,
    output logic [N_CHAN*W_OUT-1:0]  o_y,
    output logic [N_CHAN-1:0]        o_valid,
    output logic                     o_busy
`ifdef DIRTY_RECOMPUTE_ISSUECOUNT_EN
    ,
    output logic [15:0]              o_nIssued
`endif
);

    // A channel can be in flight at most once per pipe stage, so this never wraps.
    localparam int CNT_W = $clog2(PIPE_STAGES + 1);

    logic [W_IN-1:0]   x_prev_q   [N_CHAN];
    logic [W_IN-1:0]   x_prev_d   [N_CHAN];
    logic [CNT_W-1:0]  inflight_q [N_CHAN];
    logic [CNT_W-1:0]  inflight_d [N_CHAN];
    logic [W_OUT-1:0]  y_q        [N_CHAN];
    logic [W_OUT-1:0]  y_d        [N_CHAN];
    logic [N_CHAN-1:0] dirty_q;
    logic [N_CHAN-1:0] dirty_d;
    logic [N_CHAN-1:0] changed;
    logic [N_CHAN-1:0] issue;
    logic [N_CHAN-1:0] wb_hit;
    logic [CHAN_W-1:0] rr_ptr_q;
    logic [CHAN_W-1:0] rr_ptr_d;
    logic              grant_valid;
    logic [CHAN_W-1:0] grant_chan;
    payload_t          wb;

    always_comb begin
        for (int c = 0; c < N_CHAN; c++) begin
            x_prev_d[c] = i_x[c*W_IN +: W_IN];
            changed[c]  = (x_prev_d[c] != x_prev_q[c]);
        end
    end

    // Walk downward so the channel closest after rr_ptr is the last (winning) assignment.
    always_comb begin
        logic [CHAN_W-1:0] idx;
        idx         = '0;
        grant_valid = 1'b0;
        grant_chan  = '0;
        for (int i = N_CHAN; i >= 1; i--) begin
            idx = CHAN_W'((int'(rr_ptr_q) + i) % N_CHAN);
            if (dirty_q[idx]) begin
                grant_valid = 1'b1;
                grant_chan  = idx;
            end
        end
        rr_ptr_d = grant_valid ? grant_chan : rr_ptr_q;
    end

    always_comb begin
        for (int c = 0; c < N_CHAN; c++) begin
            issue[c]      = grant_valid && (grant_chan == CHAN_W'(c));
            wb_hit[c]     = wb.valid && (wb.chan == CHAN_W'(c));
            dirty_d[c]    = changed[c] | (dirty_q[c] & ~issue[c]);
            inflight_d[c] = inflight_q[c];
            if (issue[c] && !wb_hit[c]) begin
                inflight_d[c] = inflight_q[c] + CNT_W'(1);
            end else if (!issue[c] && wb_hit[c]) begin
                inflight_d[c] = inflight_q[c] - CNT_W'(1);
            end
            y_d[c] = wb_hit[c] ? wb.data : y_q[c];
        end
    end

    dirty_recompute_func #(
        .W_IN        (W_IN),
        .PIPE_STAGES (PIPE_STAGES)
    ) u_func (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_valid  (grant_valid),
        .i_chan   (grant_chan),
        .i_x      (x_prev_q[grant_chan]),
        .o_res    (wb)
    );

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int c = 0; c < N_CHAN; c++) begin
                x_prev_q[c]   <= '0;
                inflight_q[c] <= '0;
                y_q[c]        <= '0;
            end
            dirty_q  <= '0;
            rr_ptr_q <= CHAN_W'(N_CHAN - 1);
        end else begin
            for (int c = 0; c < N_CHAN; c++) begin
                x_prev_q[c]   <= x_prev_d[c];
                inflight_q[c] <= inflight_d[c];
                y_q[c]        <= y_d[c];
            end
            dirty_q  <= dirty_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        o_busy = |dirty_q;
        for (int c = 0; c < N_CHAN; c++) begin
            o_y[c*W_OUT +: W_OUT] = y_q[c];
            o_valid[c]            = ~dirty_q[c] & (inflight_q[c] == '0);
            o_busy                = o_busy | (inflight_q[c] != '0);
        end
    end

`ifdef DIRTY_RECOMPUTE_ISSUECOUNT_EN
    logic [15:0] n_issued_q;
    logic [15:0] n_issued_d;

    always_comb begin
        n_issued_d = n_issued_q;
        if (grant_valid && (n_issued_q != 16'hFFFF)) begin
            n_issued_d = n_issued_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            n_issued_q <= '0;
        end else begin
            n_issued_q <= n_issued_d;
        end
    end

    assign o_nIssued = n_issued_q;
`endif

endmodule
